// File: rtl/pid_ctrl_pipe.sv
// Two-stage PID steering controller: a signed heading error becomes left/right wheel speeds
// around a forward speed. Stage 1 registers the P/D products and the integrator; stage 2 sums and mixes.
module pid_ctrl_pipe #(
  parameter int ERR_W     = 12,
  parameter int SAT_W     = 10,
  parameter int DSAT_W    = 7,
  parameter int I_W       = 15,
  parameter int I_SHIFT   = 6,
  parameter int PID_W     = 14,
  parameter int OUT_SHIFT = 3,
  parameter int FWD_W     = 10,
  parameter int SPD_W     = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    moving,
  input  logic                    err_vld,
  input  logic signed [ERR_W-1:0] error,
  input  logic [FWD_W-1:0]        frwrd,
  input  logic [4:0]              p_coeff,
  input  logic [5:0]              d_coeff,
  input  logic [1:0]              mode,
  output logic signed [SPD_W-1:0] lft_spd,
  output logic signed [SPD_W-1:0] rght_spd,
  output logic                    spd_vld
);

  localparam int SAT_MAX  = 2**(SAT_W-1) - 1;
  localparam int SAT_MIN  = -(2**(SAT_W-1));
  localparam int DSAT_MAX = 2**(DSAT_W-1) - 1;
  localparam int DSAT_MIN = -(2**(DSAT_W-1));
  localparam logic signed [SPD_W-1:0] SPD_MAX = {1'b0, {(SPD_W-1){1'b1}}};
  localparam logic signed [SPD_W-1:0] SPD_MIN = {1'b1, {(SPD_W-1){1'b0}}};

  // stage-1 state and error history
  logic signed [SAT_W-1:0] err1_q, err1_d, err2_q, err2_d;
  logic signed [PID_W-1:0] p_q, p_d, d_q, d_d;
  logic signed [I_W-1:0]   acc_q, acc_d;
  logic                    i_en_q, i_en_d;
  // vld_pipe_q[0] = stage-1 valid, vld_pipe_q[1] = output strobe
  logic [1:0]              vld_pipe_q, vld_pipe_d;
  logic signed [SPD_W-1:0] lft_q, lft_d, rght_q, rght_d;

  logic signed [SAT_W-1:0]  err_sat;
  logic signed [SAT_W:0]    d_diff;
  logic signed [DSAT_W-1:0] d_sat;
  logic signed [I_W-1:0]    acc_add;
  logic                     i_ovf;
  logic signed [PID_W-1:0]  i_term, pid_sum;
  logic signed [SPD_W:0]    mix, fwd_ext, l_sum, r_sum;

  function automatic logic signed [SPD_W-1:0] sat_spd(input logic signed [SPD_W:0] v);
    if (v[SPD_W] != v[SPD_W-1]) return v[SPD_W] ? SPD_MIN : SPD_MAX;
    return v[SPD_W-1:0];
  endfunction

  always_comb begin
    err_sat = error[SAT_W-1:0];
    if (error > ERR_W'(SAT_MAX))      err_sat = SAT_W'(SAT_MAX);
    else if (error < ERR_W'(SAT_MIN)) err_sat = SAT_W'(SAT_MIN);

    d_diff = (SAT_W+1)'(err_sat) - (SAT_W+1)'(err2_q);
    d_sat  = d_diff[DSAT_W-1:0];
    if (d_diff > (SAT_W+1)'(DSAT_MAX))      d_sat = DSAT_W'(DSAT_MAX);
    else if (d_diff < (SAT_W+1)'(DSAT_MIN)) d_sat = DSAT_W'(DSAT_MIN);

    // anti-windup: a same-sign add that flips the sign leaves the accumulator alone
    acc_add = acc_q + I_W'(err_sat);
    i_ovf   = (acc_q[I_W-1] == err_sat[SAT_W-1]) && (acc_add[I_W-1] != acc_q[I_W-1]);
  end

  always_comb begin
    err1_d        = err1_q;
    err2_d        = err2_q;
    p_d           = p_q;
    d_d           = d_q;
    i_en_d        = i_en_q;
    acc_d         = acc_q;
    vld_pipe_d[0] = 1'b0;
    if (err_vld) begin
      err1_d = err_sat;
      err2_d = err1_q;
    end
    if (!moving) begin
      acc_d = '0;
    end else if (err_vld) begin
      p_d    = PID_W'(err_sat * $signed({1'b0, p_coeff}));
      d_d    = mode[1] ? PID_W'(d_sat * $signed({1'b0, d_coeff})) : '0;
      i_en_d = mode[0];
      if (mode[0] && !i_ovf) acc_d = acc_add;
      vld_pipe_d[0] = 1'b1;
    end
  end

  always_comb begin
    i_term  = i_en_q ? PID_W'(acc_q >>> I_SHIFT) : '0;
    pid_sum = p_q + i_term + d_q;
    mix     = (SPD_W+1)'(pid_sum >>> OUT_SHIFT);
    fwd_ext = $signed((SPD_W+1)'(frwrd));
    l_sum   = fwd_ext + mix;
    r_sum   = fwd_ext - mix;

    lft_d         = lft_q;
    rght_d        = rght_q;
    vld_pipe_d[1] = 1'b0;
    if (!moving) begin
      lft_d  = '0;
      rght_d = '0;
    end else if (vld_pipe_q[0]) begin
      lft_d         = sat_spd(l_sum);
      rght_d        = sat_spd(r_sum);
      vld_pipe_d[1] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err1_q     <= '0;
      err2_q     <= '0;
      p_q        <= '0;
      d_q        <= '0;
      i_en_q     <= 1'b0;
      acc_q      <= '0;
      vld_pipe_q <= '0;
      lft_q      <= '0;
      rght_q     <= '0;
    end else begin
      err1_q     <= err1_d;
      err2_q     <= err2_d;
      p_q        <= p_d;
      d_q        <= d_d;
      i_en_q     <= i_en_d;
      acc_q      <= acc_d;
      vld_pipe_q <= vld_pipe_d;
      lft_q      <= lft_d;
      rght_q     <= rght_d;
    end
  end

  assign lft_spd  = lft_q;
  assign rght_spd = rght_q;
  assign spd_vld  = vld_pipe_q[1];

endmodule

// File: tb/tb_pid_ctrl_pipe.sv
// Directed bench for pid_ctrl_pipe: a P-only vector table plus hand-built sequences for
// streaming, integrator, anti-windup, D path, moving drop and async reset.
module tb_pid_ctrl_pipe;

  logic               clk = 1'b0;
  logic               rst, moving, err_vld;
  logic signed [11:0] error;
  logic [9:0]         frwrd;
  logic [4:0]         p_coeff;
  logic [5:0]         d_coeff;
  logic [1:0]         mode;
  logic signed [10:0] lft_spd, rght_spd;
  logic               spd_vld;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]         mode;
    logic [4:0]         p;
    logic [9:0]         f;
    logic signed [11:0] e;
    int                 el;
    int                 er;
  } vec_t;

  vec_t tbl[9];
  logic signed [11:0] eq[$];
  int lq[$];
  int rq[$];

  pid_ctrl_pipe dut (
    .clk(clk), .rst(rst), .moving(moving), .err_vld(err_vld), .error(error),
    .frwrd(frwrd), .p_coeff(p_coeff), .d_coeff(d_coeff), .mode(mode),
    .lft_spd(lft_spd), .rght_spd(rght_spd), .spd_vld(spd_vld)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string name, input logic signed [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic set_cfg(input logic [1:0] m, input logic [4:0] p, input logic [5:0] d,
                         input logic [9:0] f);
    mode = m; p_coeff = p; d_coeff = d; frwrd = f;
  endtask

  // single sample: strobe must be low one cycle later and high two cycles later
  task automatic apply_one(input string name, input logic signed [11:0] e, input int el, input int er);
    error = e; err_vld = 1'b1;
    @(negedge clk);
    err_vld = 1'b0;
    chk({name, " vld T+1"}, spd_vld, 0);
    @(negedge clk);
    chk({name, " vld T+2"}, spd_vld, 1);
    chk({name, " lft"}, lft_spd, el);
    chk({name, " rght"}, rght_spd, er);
  endtask

  // back-to-back err_vld for every entry of eq; collect every strobed output
  task automatic run_stream();
    lq.delete(); rq.delete();
    for (int i = 0; i < eq.size(); i++) begin
      error = eq[i]; err_vld = 1'b1;
      @(negedge clk);
      if (spd_vld) begin lq.push_back(lft_spd); rq.push_back(rght_spd); end
    end
    err_vld = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (spd_vld) begin lq.push_back(lft_spd); rq.push_back(rght_spd); end
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{2'b00, 5'd8,  10'd256,  12'sd80,   336,   176};
    tbl[1] = '{2'b00, 5'd8,  10'd1023, 12'sh7FF,  1023,  512};
    tbl[2] = '{2'b00, 5'd8,  10'd0,    12'sh800,  -512,  512};
    tbl[3] = '{2'b00, 5'd31, 10'd500,  -12'sd100, 112,   888};
    tbl[4] = '{2'b00, 5'd1,  10'd0,    -12'sd1,   -1,    1};
    tbl[5] = '{2'b00, 5'd31, 10'd1023, 12'sd200,  1023,  248};
    tbl[6] = '{2'b00, 5'd31, 10'd0,    -12'sd250, -969,  969};
    tbl[7] = '{2'b00, 5'd0,  10'd700,  12'sd50,   700,   700};
    tbl[8] = '{2'b00, 5'd16, 10'd0,    -12'sd600, -1024, 1023};

    rst = 1'b1; moving = 1'b1; err_vld = 1'b0; error = '0;
    set_cfg(2'b00, 5'd0, 6'd0, 10'd0);
    #12;
    chk("reset lft", lft_spd, 0);
    chk("reset rght", rght_spd, 0);
    chk("reset vld", spd_vld, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      set_cfg(tbl[i].mode, tbl[i].p, 6'd0, tbl[i].f);
      apply_one($sformatf("vec%0d", i), tbl[i].e, tbl[i].el, tbl[i].er);
    end

    // back-to-back P samples come out one per cycle, in order
    set_cfg(2'b00, 5'd8, 6'd0, 10'd256);
    eq = '{12'sd80, 12'sd16, -12'sd40};
    run_stream();
    chk("b2b count", lq.size(), 3);
    if (lq.size() == 3) begin
      chk("b2b l0", lq[0], 336); chk("b2b r0", rq[0], 176);
      chk("b2b l1", lq[1], 272); chk("b2b r1", rq[1], 240);
      chk("b2b l2", lq[2], 216); chk("b2b r2", rq[2], 296);
    end

    // PD: errors 0,0,40 -> D=440 on the third sample
    pulse_rst();
    set_cfg(2'b10, 5'd0, 6'd11, 10'd100);
    eq = '{12'sd0, 12'sd0, 12'sd40};
    run_stream();
    chk("pd count", lq.size(), 3);
    if (lq.size() == 3) begin
      chk("pd l0", lq[0], 100);
      chk("pd l2", lq[2], 155);
      chk("pd r2", rq[2], 45);
    end

    // PI: 64 samples of 64 -> acc 4096, I 64, m 8
    pulse_rst();
    set_cfg(2'b01, 5'd0, 6'd0, 10'd0);
    eq.delete();
    repeat (64) eq.push_back(12'sd64);
    run_stream();
    chk("pi count", lq.size(), 64);
    if (lq.size() == 64) begin
      chk("pi l7", lq[7], 1);
      chk("pi l63", lq[63], 8);
      chk("pi r63", rq[63], -8);
    end

    // anti-windup: accumulator stops at 16352, I=255, m=31
    pulse_rst();
    set_cfg(2'b01, 5'd0, 6'd0, 10'd0);
    eq.delete();
    repeat (40) eq.push_back(12'sd511);
    run_stream();
    chk("windup count", lq.size(), 40);
    if (lq.size() == 40) begin
      chk("windup l31", lq[31], 31);
      chk("windup l39", lq[39], 31);
      chk("windup r39", rq[39], -31);
    end

    // moving drop: in-flight sample lost, outputs zeroed, integrator cleared
    pulse_rst();
    set_cfg(2'b01, 5'd0, 6'd0, 10'd100);
    eq.delete();
    repeat (64) eq.push_back(12'sd64);
    run_stream();
    chk("mv pre l", lq.size() == 64 ? lq[63] : -9999, 108);
    set_cfg(2'b00, 5'd8, 6'd0, 10'd256);
    apply_one("mv base", 12'sd80, 336, 176);
    error = 12'sd80; err_vld = 1'b1;
    @(negedge clk);
    err_vld = 1'b0; moving = 1'b0;
    @(negedge clk);
    chk("mv drop vld", spd_vld, 0);
    chk("mv drop lft", lft_spd, 0);
    chk("mv drop rght", rght_spd, 0);
    err_vld = 1'b1;
    @(negedge clk);
    err_vld = 1'b0; moving = 1'b1;
    @(negedge clk);
    chk("mv discard vld1", spd_vld, 0);
    @(negedge clk);
    chk("mv discard vld2", spd_vld, 0);
    set_cfg(2'b01, 5'd0, 6'd0, 10'd100);
    apply_one("mv acc clr", 12'sd64, 100, 100);

    // async reset with a sample in flight
    set_cfg(2'b00, 5'd8, 6'd0, 10'd256);
    apply_one("rst base", 12'sd80, 336, 176);
    error = 12'sd80; err_vld = 1'b1;
    @(negedge clk);
    err_vld = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst lft", lft_spd, 0);
    chk("arst rght", rght_spd, 0);
    chk("arst vld", spd_vld, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst lost vld", spd_vld, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
